// File: rtl/vlc_manchester_tx.sv
// Manchester frame transmitter for the VLC LED driver.
// Pulls FRAME_WORDS words from the payload FIFO and sends one frame:
// preamble (0x55 bytes), SOF (0xD5), payload words MSB first, and an
// 8-bit additive checksum. Each bit is sent as two CLK_DIV-cycle halves.
module vlc_manchester_tx #(
   parameter int D_WIDTH     = 32,
   parameter int NUM_WIDTH   = 10,
   parameter int FRAME_WORDS = 8,
   parameter int PRE_BYTES   = 2,
   parameter int CLK_DIV     = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 tx_en,
   input  logic [D_WIDTH-1:0]   fifo_d_out,
   input  logic                 fifo_empty,
   input  logic [NUM_WIDTH-1:0] fifo_data_num,
   output logic                 fifo_r_en,
   output logic                 led_out,
   output logic                 busy,
   output logic                 frame_done,
   output logic                 underrun
);

   localparam int PRE_BITS = 8 * PRE_BYTES;
   localparam int MAX_BITS = (PRE_BITS > D_WIDTH) ? PRE_BITS : D_WIDTH;
   localparam int CNT_W    = $clog2(MAX_BITS);
   localparam int DIV_W    = $clog2(CLK_DIV);

   localparam logic [CNT_W-1:0]     PRE_LAST  = CNT_W'(PRE_BITS - 1);
   localparam logic [CNT_W-1:0]     WORD_LAST = CNT_W'(D_WIDTH - 1);
   localparam logic [CNT_W-1:0]     BYTE_LAST = CNT_W'(7);
   localparam logic [DIV_W-1:0]     DIV_LAST  = DIV_W'(CLK_DIV - 1);
   localparam logic [NUM_WIDTH-1:0] LAST_WORD = NUM_WIDTH'(FRAME_WORDS - 1);
   localparam logic [NUM_WIDTH-1:0] FRAME_NUM = NUM_WIDTH'(FRAME_WORDS);
   localparam logic [7:0]           SOF_BYTE  = 8'hD5;

   typedef enum logic [2:0] {IDLE, PRE, SOF, PAY, CHK} state_t;

   state_t               state;
   state_t               state_next;
   logic [DIV_W-1:0]     div_cnt;
   logic                 half;
   logic [CNT_W-1:0]     bit_cnt;
   logic [NUM_WIDTH-1:0] word_cnt;
   logic [D_WIDTH-1:0]   shift_reg;
   logic [D_WIDTH-1:0]   prefetch;
   logic [7:0]           checksum;
   logic                 rd_pend;
   logic                 word_first;
   logic                 done_q;
   logic                 underrun_q;

   logic half_end;
   logic bit_end;
   logic field_last_bit;
   logic word_end;
   logic start;
   logic fetch_try;
   logic attempt;
   logic load;
   logic cur_bit;

   // Modulo-256 sum of all bytes in one payload word.
   function automatic logic [7:0] byte_sum(input logic [D_WIDTH-1:0] w);
      logic [7:0] s;
      s = '0;
      for (int i = 0; i < D_WIDTH / 8; i++) begin
         s = s + w[8*i +: 8];
      end
      return s;
   endfunction

   // Timing strobes, field boundaries and FIFO fetch decisions.
   always_comb begin
      half_end  = (div_cnt == DIV_LAST);
      bit_end   = half_end && half;
      word_end  = (state == PAY) && (bit_cnt == WORD_LAST);
      field_last_bit = 1'b0;
      case (state)
         PRE:     field_last_bit = (bit_cnt == PRE_LAST);
         SOF:     field_last_bit = (bit_cnt == BYTE_LAST);
         PAY:     field_last_bit = word_end && (word_cnt == LAST_WORD);
         CHK:     field_last_bit = (bit_cnt == BYTE_LAST);
         default: field_last_bit = 1'b0;
      endcase
      start     = (state == IDLE) && !done_q && tx_en &&
                  (fifo_data_num >= FRAME_NUM) && !reset;
      fetch_try = (state == PAY) && word_first && (word_cnt < LAST_WORD) && !reset;
      attempt   = start || fetch_try;
      load      = bit_end && (((state == SOF) && field_last_bit) ||
                              (word_end && (word_cnt != LAST_WORD)));
   end

   // State register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic: each field advances after its last bit ends.
   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (start) state_next = PRE;
         PRE:     if (bit_end && field_last_bit) state_next = SOF;
         SOF:     if (bit_end && field_last_bit) state_next = PAY;
         PAY:     if (bit_end && field_last_bit) state_next = CHK;
         CHK:     if (bit_end && field_last_bit) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Output logic: line level is the current bit, inverted in the second half.
   always_comb begin
      cur_bit = 1'b0;
      case (state)
         PRE:     cur_bit = bit_cnt[0];
         SOF:     cur_bit = SOF_BYTE[~bit_cnt[2:0]];
         PAY:     cur_bit = shift_reg[D_WIDTH-1];
         CHK:     cur_bit = checksum[~bit_cnt[2:0]];
         default: cur_bit = 1'b0;
      endcase
      led_out    = (state != IDLE) && (cur_bit ^ half);
      fifo_r_en  = attempt && !fifo_empty;
      busy       = (state != IDLE);
      frame_done = done_q;
      underrun   = underrun_q;
   end

   // Datapath: bit timing, word shifting, prefetch capture and checksum.
   always_ff @(posedge clk) begin
      if (reset) begin
         div_cnt    <= '0;
         half       <= 1'b0;
         bit_cnt    <= '0;
         word_cnt   <= '0;
         shift_reg  <= '0;
         prefetch   <= '0;
         checksum   <= '0;
         rd_pend    <= 1'b0;
         word_first <= 1'b0;
         done_q     <= 1'b0;
         underrun_q <= 1'b0;
      end else begin
         done_q     <= (state == CHK) && bit_end && field_last_bit;
         rd_pend    <= fifo_r_en;
         word_first <= load;
         if (attempt && fifo_empty) begin
            prefetch   <= '0;
            underrun_q <= 1'b1;
         end else if (rd_pend) begin
            prefetch <= fifo_d_out;
         end
         if (state == IDLE) begin
            div_cnt   <= '0;
            half      <= 1'b0;
            bit_cnt   <= '0;
            word_cnt  <= '0;
            shift_reg <= '0;
            if (start) begin
               checksum <= '0;
            end
         end else begin
            if (half_end) begin
               div_cnt <= '0;
               half    <= ~half;
            end else begin
               div_cnt <= div_cnt + 1'b1;
            end
            if (bit_end) begin
               bit_cnt <= (field_last_bit || word_end) ? '0 : bit_cnt + 1'b1;
               if (word_end) begin
                  word_cnt <= word_cnt + 1'b1;
               end
               if (load) begin
                  shift_reg <= prefetch;
                  checksum  <= checksum + byte_sum(prefetch);
               end else begin
                  shift_reg <= shift_reg << 1;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_vlc_manchester_tx.sv
// Self-checking bench for vlc_manchester_tx: two instances (CLK_DIV=4 with
// two-word frames, CLK_DIV=2 with one-word frames) fed by queue FIFO models.
module tb_vlc_manchester_tx;

   localparam int DW    = 32;
   localparam int NW    = 10;
   localparam int PRE   = 2;
   localparam int FW_A  = 2;
   localparam int DIV_A = 4;
   localparam int FW_B  = 1;
   localparam int DIV_B = 2;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          reset;
   logic          tx_en_a, tx_en_b;
   logic [DW-1:0] d_out_a, d_out_b;
   logic          empty_a, empty_b;
   logic [NW-1:0] num_a, num_b;
   logic          ren_a, led_a, busy_a, done_a, under_a;
   logic          ren_b, led_b, busy_b, done_b, under_b;

   vlc_manchester_tx #(.D_WIDTH(DW), .NUM_WIDTH(NW), .FRAME_WORDS(FW_A),
                       .PRE_BYTES(PRE), .CLK_DIV(DIV_A)) dut_a (
      .clk(clk), .reset(reset), .tx_en(tx_en_a), .fifo_d_out(d_out_a),
      .fifo_empty(empty_a), .fifo_data_num(num_a), .fifo_r_en(ren_a),
      .led_out(led_a), .busy(busy_a), .frame_done(done_a), .underrun(under_a));

   vlc_manchester_tx #(.D_WIDTH(DW), .NUM_WIDTH(NW), .FRAME_WORDS(FW_B),
                       .PRE_BYTES(PRE), .CLK_DIV(DIV_B)) dut_b (
      .clk(clk), .reset(reset), .tx_en(tx_en_b), .fifo_d_out(d_out_b),
      .fifo_empty(empty_b), .fifo_data_num(num_b), .fifo_r_en(ren_b),
      .led_out(led_b), .busy(busy_b), .frame_done(done_b), .underrun(under_b));

   logic [DW-1:0] qa[$];
   logic [DW-1:0] qb[$];
   logic          hold_empty_a, hold_empty_b;
   logic          cur_led[2], cur_ren[2], cur_busy[2], cur_done[2], cur_under[2];
   int            checks = 0;
   int            errors = 0;

   // FIFO flags follow the queue contents unless the bench pins empty high.
   task automatic updateFlags();
      empty_a = (qa.size() == 0) || hold_empty_a;
      empty_b = (qb.size() == 0) || hold_empty_b;
      num_a   = NW'(qa.size());
      num_b   = NW'(qb.size());
   endtask

   // One clock cycle: sample outputs mid-cycle, then model the FIFO read.
   task automatic tick();
      @(negedge clk);
      cur_led[0] = led_a;  cur_ren[0] = ren_a;  cur_busy[0] = busy_a;
      cur_done[0] = done_a; cur_under[0] = under_a;
      cur_led[1] = led_b;  cur_ren[1] = ren_b;  cur_busy[1] = busy_b;
      cur_done[1] = done_b; cur_under[1] = under_b;
      @(posedge clk);
      #1;
      if (cur_ren[0]) d_out_a = (qa.size() > 0) ? qa.pop_front() : 32'hDEADBEEF;
      if (cur_ren[1]) d_out_b = (qb.size() > 0) ? qb.pop_front() : 32'hDEADBEEF;
      updateFlags();
   endtask

   task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic applyStimulus(input int sel, input logic [DW-1:0] w);
      if (sel == 0) qa.push_back(w);
      else          qb.push_back(w);
      updateFlags();
   endtask

   // Reference frame: preamble, SOF, payload bytes MSB first, byte-sum checksum.
   task automatic buildBytes(input logic [DW-1:0] words[$], output logic [7:0] bytes[$]);
      logic [7:0] sum;
      logic [DW-1:0] w;
      bytes.delete();
      sum = 8'h00;
      for (int i = 0; i < PRE; i++) bytes.push_back(8'h55);
      bytes.push_back(8'hD5);
      foreach (words[k]) begin
         w = words[k];
         for (int b = DW / 8 - 1; b >= 0; b--) begin
            bytes.push_back(w[8*b +: 8]);
            sum = sum + w[8*b +: 8];
         end
      end
      bytes.push_back(sum);
   endtask

   // Waits for a frame start, records the whole line waveform and checks it.
   task automatic runFrame(input int sel, input logic [DW-1:0] tx_words[$], input int exp_ren,
                           input bit under_mid, input bit drop_tx, input string tag,
                           output int wait_cycles);
      int div, fw, ncyc, n, ren_cnt, done_cnt, busy_bad, fails, nbits;
      logic samples[$];
      logic [7:0] bytes[$];
      logic [31:0] obs, exp;
      logic bitv;
      div  = (sel == 0) ? DIV_A : DIV_B;
      fw   = (sel == 0) ? FW_A : FW_B;
      nbits = 8 * PRE + 8 + DW * fw + 8;
      ncyc = 2 * div * nbits;
      n = 0;
      do begin
         tick();
         n++;
      end while (!cur_ren[sel] && n < 60);
      wait_cycles = n;
      checkOutput({tag, ".start_ren"}, 64'(cur_ren[sel]), 64'd1);
      if (!cur_ren[sel]) return;
      if (under_mid) begin
         if (sel == 0) hold_empty_a = 1'b1;
         else          hold_empty_b = 1'b1;
         updateFlags();
      end
      ren_cnt = 0; done_cnt = 0; busy_bad = 0;
      for (int i = 1; i <= ncyc; i++) begin
         tick();
         samples.push_back(cur_led[sel]);
         ren_cnt  += int'(cur_ren[sel]);
         done_cnt += int'(cur_done[sel]);
         busy_bad += int'(!cur_busy[sel]);
         if (drop_tx && i == ncyc / 2) begin
            if (sel == 0) tx_en_a = 1'b0;
            else          tx_en_b = 1'b0;
         end
      end
      tick();
      checkOutput({tag, ".frame_done"}, 64'(cur_done[sel]), 64'd1);
      checkOutput({tag, ".busy_end"},   64'(cur_busy[sel]), 64'd0);
      checkOutput({tag, ".led_idle"},   64'(cur_led[sel]),  64'd0);
      hold_empty_a = 1'b0;
      hold_empty_b = 1'b0;
      updateFlags();
      checkOutput({tag, ".fetches"},    64'(ren_cnt),  64'(exp_ren));
      checkOutput({tag, ".early_done"}, 64'(done_cnt), 64'd0);
      checkOutput({tag, ".busy_low"},   64'(busy_bad), 64'd0);
      buildBytes(tx_words, bytes);
      fails = 0;
      for (int b = 0; b < nbits; b++) begin
         bitv = bytes[b / 8][7 - (b % 8)];
         obs = '0;
         exp = '0;
         for (int j = 0; j < 2 * div; j++) begin
            obs = {obs[30:0], samples[b * 2 * div + j]};
            exp = {exp[30:0], (j < div) ? bitv : ~bitv};
         end
         if (fails < 4) checkOutput($sformatf("%s.bit%0d", tag, b), 64'(obs), 64'(exp));
         if (obs !== exp) fails++;
      end
   endtask

   // Abort guard so a stuck run still reports and ends.
   initial begin
      #3000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   // Directed sequence of scenarios with random payload data.
   initial begin
      logic [DW-1:0] words[$];
      logic [DW-1:0] r0, r1, r2, r3;
      int w, bad, done_bad, n;

      reset = 1'b1; tx_en_a = 1'b0; tx_en_b = 1'b0;
      d_out_a = '0; d_out_b = '0;
      hold_empty_a = 1'b0; hold_empty_b = 1'b0;
      updateFlags();
      repeat (3) tick();
      reset = 1'b0;
      tick();
      for (int s = 0; s < 2; s++) begin
         checkOutput($sformatf("reset%0d.led", s),   64'(cur_led[s]),   64'd0);
         checkOutput($sformatf("reset%0d.busy", s),  64'(cur_busy[s]),  64'd0);
         checkOutput($sformatf("reset%0d.done", s),  64'(cur_done[s]),  64'd0);
         checkOutput($sformatf("reset%0d.under", s), 64'(cur_under[s]), 64'd0);
         checkOutput($sformatf("reset%0d.ren", s),   64'(cur_ren[s]),   64'd0);
      end

      // Basic two-word frame with the reference payload.
      applyStimulus(0, 32'h12345678);
      applyStimulus(0, 32'h9ABCDEF0);
      tx_en_a = 1'b1;
      words.delete(); words.push_back(32'h12345678); words.push_back(32'h9ABCDEF0);
      runFrame(0, words, 1, 1'b0, 1'b0, "basic", w);
      checkOutput("basic.underrun", 64'(cur_under[0]), 64'd0);

      // Start threshold: one queued word must not start a frame.
      r0 = $urandom(); r1 = $urandom();
      applyStimulus(0, r0);
      bad = 0;
      for (int i = 0; i < 10; i++) begin
         tick();
         bad += int'(cur_ren[0]) + int'(cur_busy[0]) + int'(cur_led[0]);
      end
      checkOutput("thresh.idle", 64'(bad), 64'd0);
      applyStimulus(0, r1);
      words.delete(); words.push_back(r0); words.push_back(r1);
      runFrame(0, words, 1, 1'b0, 1'b0, "thresh", w);
      checkOutput("thresh.start_delay", 64'(w), 64'd1);

      // Underrun at the word-1 fetch: zero substituted, flag sticky.
      r0 = $urandom(); r1 = $urandom();
      applyStimulus(0, r0); applyStimulus(0, r1);
      words.delete(); words.push_back(r0); words.push_back(32'h0);
      runFrame(0, words, 0, 1'b1, 1'b0, "under", w);
      checkOutput("under.flag", 64'(cur_under[0]), 64'd1);
      qa.delete(); updateFlags();
      r0 = $urandom(); r1 = $urandom();
      applyStimulus(0, r0); applyStimulus(0, r1);
      words.delete(); words.push_back(r0); words.push_back(r1);
      runFrame(0, words, 1, 1'b0, 1'b0, "after_under", w);
      checkOutput("after_under.flag", 64'(cur_under[0]), 64'd1);

      // Reset during the 20th payload bit, then a clean frame.
      r0 = $urandom(); r1 = $urandom();
      applyStimulus(0, r0); applyStimulus(0, r1);
      n = 0;
      do begin tick(); n++; end while (!cur_ren[0] && n < 60);
      checkOutput("midreset.start", 64'(cur_ren[0]), 64'd1);
      done_bad = 0;
      for (int i = 0; i < (24 + 19) * 2 * DIV_A + 3; i++) begin
         tick();
         done_bad += int'(cur_done[0]);
      end
      tx_en_a = 1'b0;
      reset = 1'b1;
      tick();
      reset = 1'b0;
      tick();
      done_bad += int'(cur_done[0]);
      checkOutput("midreset.led",  64'(cur_led[0]),  64'd0);
      checkOutput("midreset.busy", 64'(cur_busy[0]), 64'd0);
      checkOutput("midreset.done", 64'(done_bad),    64'd0);
      qa.delete(); updateFlags();
      r0 = $urandom(); r1 = $urandom();
      applyStimulus(0, r0); applyStimulus(0, r1);
      tx_en_a = 1'b1;
      words.delete(); words.push_back(r0); words.push_back(r1);
      runFrame(0, words, 1, 1'b0, 1'b0, "post_reset", w);
      checkOutput("post_reset.under", 64'(cur_under[0]), 64'd0);

      // Back-to-back frames, tx_en dropped during the second.
      r0 = $urandom(); r1 = $urandom(); r2 = $urandom(); r3 = $urandom();
      applyStimulus(0, r0); applyStimulus(0, r1); applyStimulus(0, r2); applyStimulus(0, r3);
      words.delete(); words.push_back(r0); words.push_back(r1);
      runFrame(0, words, 1, 1'b0, 1'b0, "b2b1", w);
      words.delete(); words.push_back(r2); words.push_back(r3);
      runFrame(0, words, 1, 1'b0, 1'b1, "b2b2", w);
      checkOutput("b2b2.start_gap", 64'(w), 64'd1);
      applyStimulus(0, $urandom()); applyStimulus(0, $urandom());
      bad = 0;
      for (int i = 0; i < 20; i++) begin
         tick();
         bad += int'(cur_ren[0]) + int'(cur_busy[0]) + int'(cur_led[0]);
      end
      checkOutput("txoff.idle", 64'(bad), 64'd0);
      qa.delete(); updateFlags();

      // Random-payload frames.
      tx_en_a = 1'b1;
      for (int k = 0; k < 3; k++) begin
         r0 = $urandom(); r1 = $urandom();
         applyStimulus(0, r0); applyStimulus(0, r1);
         words.delete(); words.push_back(r0); words.push_back(r1);
         runFrame(0, words, 1, 1'b0, 1'b0, $sformatf("rand%0d", k), w);
      end
      tx_en_a = 1'b0;

      // Fast instance: 2-cycle half-bits, one-word frames.
      applyStimulus(1, 32'hFFFFFFFF);
      tx_en_b = 1'b1;
      words.delete(); words.push_back(32'hFFFFFFFF);
      runFrame(1, words, 0, 1'b0, 1'b0, "fast_ff", w);
      r0 = $urandom();
      applyStimulus(1, r0);
      words.delete(); words.push_back(r0);
      runFrame(1, words, 0, 1'b0, 1'b0, "fast_rand", w);
      checkOutput("fast.under", 64'(cur_under[1]), 64'd0);
      tx_en_b = 1'b0;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/vlc_manchester_tx.md
Name: vlc_manchester_tx

Overview:
Downstream consumer of the dual-clock payload FIFO, running in the FIFO read-clock domain. It pulls fixed-size frames of words out of the FIFO and serialises them MSB-first. Each frame is preamble + SOF + payload + 8-bit checksum, Manchester-encoded. The output led_out drives the VLC LED driver directly.

Parameters:
D_WIDTH, 32, FIFO word width; must be a multiple of 8
NUM_WIDTH, 10, width of the FIFO occupancy count
FRAME_WORDS, 8, payload words per frame; range 1..2^NUM_WIDTH-1
PRE_BYTES, 2, number of 0x55 preamble bytes; range 1..15
CLK_DIV, 16, clk cycles per Manchester half-bit; must be >= 2

Ports:
clk  in  1  clock; same clock as the FIFO r_clk
reset  in  1  synchronous, active-high
tx_en  in  1  permission to start a new frame; sampled only in IDLE
fifo_d_out  in  D_WIDTH  FIFO read data; valid the cycle after fifo_r_en
fifo_empty  in  1  FIFO empty flag
fifo_data_num  in  NUM_WIDTH  FIFO occupancy
fifo_r_en  out  1  FIFO read strobe, one-cycle pulse
led_out  out  1  Manchester line output
busy  out  1  high from frame start until the cycle before frame_done
frame_done  out  1  one-cycle pulse when a frame finishes
underrun  out  1  sticky; set on any fetch attempted while fifo_empty=1

Behaviour:
- Reset (synchronous, takes effect at the next clk edge): state=IDLE; led_out=0, fifo_r_en=0, busy=0, frame_done=0, underrun=0. All counters, the shift register and the prefetch register clear. Words already read from the FIFO are discarded. Reset may occur mid-frame.
- States: IDLE, PRE, SOF, PAY, CHK.
- IDLE -> PRE: at cycle T when tx_en=1 and fifo_data_num >= FRAME_WORDS.
  - fifo_r_en=1 in cycle T (prefetch of word 0).
  - At T+1, fifo_d_out is captured into the prefetch register and bit 0 of the preamble begins on led_out.
- Bit timing:
  - Each bit is two half-bits of CLK_DIV cycles each, so 2*CLK_DIV cycles per bit.
  - Bit=1 gives led_out high then low. Bit=0 gives led_out low then high.
  - Bits are back-to-back with no gap between fields.
- PRE: PRE_BYTES bytes of 0x55, MSB first. PRE -> SOF after the last preamble bit.
- SOF: byte 0xD5, MSB first. SOF -> PAY.
- PAY:
  - At the first cycle of each word, the shift register loads from the prefetch register. Serialisation is MSB first, D_WIDTH bits per word.
  - In that same cycle, if more words remain in the frame, a fetch is issued. The fetched data is captured into the prefetch register one cycle later.
  - After FRAME_WORDS words, PAY -> CHK.
- Fetch rule:
  - If fifo_empty=0: fifo_r_en=1 for exactly one cycle.
  - If fifo_empty=1: fifo_r_en stays 0, underrun is set, and 0 is substituted for that word. The frame continues with unchanged timing.
- Checksum:
  - 8-bit sum, mod 256, of all payload bytes as transmitted (substituted zeros included).
  - Accumulated as each word loads; cleared at frame start.
- CHK: the checksum byte is sent MSB first. After its last half-bit ends, the next cycle returns to IDLE.
- Frame end:
  - frame_done=1 for that one cycle.
  - busy=0 from that cycle.
  - led_out=0 in IDLE.
- A new frame may start in the cycle after frame_done, but no earlier.
- Total frame bits: 8*PRE_BYTES + 8 + D_WIDTH*FRAME_WORDS + 8. Total frame cycles: 2*CLK_DIV times that.
- tx_en deasserted mid-frame has no effect; the frame completes.
- fifo_r_en is never asserted in IDLE except at a start cycle, and never in CHK.
- Exactly FRAME_WORDS fetches are attempted per frame.
- underrun clears only on reset.

Test Plan:
- Default params except PRE_BYTES=2, FRAME_WORDS=2, CLK_DIV=4; FIFO model preloaded with 0x12345678, 0x9ABCDEF0; tx_en=1.
  - Required: one fifo_r_en pulse at start and one during word 0.
  - Decoded stream is 0x55 0x55 0xD5 12 34 56 78 9A BC DE F0 0x38; 96 bits = 768 cycles.
  - frame_done single pulse; underrun=0.
- Same config, fifo_data_num=1 with tx_en=1: stays IDLE, no fifo_r_en, led_out=0. Raise to 2: frame starts the next cycle.
- Same config, bench forces fifo_empty=1 at the word-1 fetch:
  - No fifo_r_en pulse, underrun=1.
  - Word 1 is sent as 0x00000000; checksum is 0x14 (= 0x114 mod 256).
  - underrun stays 1 across a subsequent good frame.
- Assert reset in the 20th payload bit: next edge gives led_out=0, busy=0, no frame_done; with tx_en=1 and 2 words, a clean new frame starts.
- tx_en=1 with 4 words queued: two back-to-back frames, second start exactly 1 cycle after first frame_done. tx_en dropped mid-frame 2: frame 2 completes, then IDLE.
- CLK_DIV=2, FRAME_WORDS=1: check half-bit width = 2 cycles and every bit has a mid-bit transition; data 0xFFFFFFFF gives checksum 0xFC.
